// File: rtl/rv32_pkg.sv
// rv32_pkg: shared fetch-stage types and constants.
package rv32_pkg;
    localparam int FETCH_FIFO_DEPTH = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry {instr, pc} buffer with push, pop and flush.
module fetch_fifo
    import rv32_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);
    fetch_entry_t mem [FETCH_FIFO_DEPTH];
    logic wr_ptr, rd_ptr;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr ^ push_i;
            rd_ptr  <= rd_ptr ^ pop_i;
            count_o <= count_o + {1'b0, push_i} - {1'b0, pop_i};
        end
    end
    // Payload needs no reset: it is only observed while count_o is nonzero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr] <= entry_i;
    end
    assign head_o = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with two-deep buffer, redirect flush and
// draining of responses that belong to abandoned requests.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o
);
    fetch_state_e state, state_n;
    logic [31:0]  fetch_pc, resp_pc, redirect_base;
    logic [1:0]   outstanding, discard_cnt, discard_n, fifo_count;
    logic         grant, push, pop, unused_redirect_lsbs;
    fetch_entry_t head;

    assign redirect_base        = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    // In-flight plus buffered never exceeds the buffer size, so a push always has room.
    assign imem_req_o    = state == RUN && !redirect_i &&
                           ({1'b0, outstanding} + {1'b0, fifo_count} < 3'(FIFO_DEPTH));
    assign imem_addr_o   = fetch_pc;
    assign grant         = imem_req_o && imem_gnt_i;
    assign push          = imem_rvalid_i && state == RUN && !redirect_i;
    assign instr_valid_o = fifo_count != 2'd0 && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign discard_n     = outstanding - {1'b0, imem_rvalid_i};

    always_comb begin
        state_n = redirect_i ? (discard_n != 2'd0 ? DRAIN : RUN) :
                  state == DRAIN ? (imem_rvalid_i && discard_cnt == 2'd1 ? RUN : DRAIN) : RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= redirect_i ? redirect_base : grant ? fetch_pc + 32'd4 : fetch_pc;
            resp_pc     <= redirect_i ? redirect_base : push ? resp_pc + 32'd4 : resp_pc;
            outstanding <= outstanding + {1'b0, grant} - {1'b0, imem_rvalid_i};
            discard_cnt <= redirect_i ? discard_n :
                           (state == DRAIN && imem_rvalid_i) ? discard_cnt - 2'd1 : discard_cnt;
        end
    end

    fetch_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .entry_i ('{instr: imem_rdata_i, pc: resp_pc}),
        .head_o  (head),
        .count_o (fifo_count)
    );

    assign instr_o  = head.instr;
    assign pc_o     = head.pc;
    assign opcode_o = head.instr[6:0];
    assign funct3_o = head.instr[14:12];
    assign funct7_o = head.instr[31:25];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode stimulus checked against a
// stream-level model (expected PC sequence, in-flight and buffered counts).
module tb_fetch_unit;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic        redirect_i = 1'b0, instr_valid_o, instr_ready_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0, redirect_pc_i = '0, instr_o, pc_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o;

    typedef struct {
        int          epoch;
        logic [31:0] addr;
    } pend_t;
    pend_t pend[$];

    int checks = 0, errors = 0;
    int epoch = 0, buffered = 0, cyc = 0;
    int gnt_pct = 100, rv_pct = 100, rdy_pct = 0;
    int dut_grants = 0, dut_xfers = 0, first_gnt = -1, first_val = -1;
    logic [31:0] exp_pc = '0, exp_fetch = '0, first_pc, first_addr, last_dut_pc;
    bit running = 1'b0, fresh_pc = 1'b0, fresh_addr = 1'b0;

    fetch_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
        bit g, rv, exp_req, exp_valid;
        int stale;
        pend_t e;
        logic [31:0] w;
        g  = $urandom_range(99) < gnt_pct;
        rv = pend.size() > 0 && $urandom_range(99) < rv_pct;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
        instr_ready_i = $urandom_range(99) < rdy_pct;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        #1;
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        exp_req   = running && stale == 0 && pend.size() + buffered < 2 && !redir;
        exp_valid = buffered > 0 && !redir;
        chk("imem_req", imem_req_o, exp_req);
        chk("instr_valid", instr_valid_o, exp_valid);
        if (imem_req_o) begin
            chk("imem_addr", imem_addr_o, exp_fetch);
            if (fresh_addr) begin first_addr = imem_addr_o; fresh_addr = 1'b0; end
            if (g) begin dut_grants++; if (first_gnt < 0) first_gnt = cyc; end
        end
        if (instr_valid_o) begin
            w = mem_word(exp_pc);
            chk("pc_o", pc_o, exp_pc);
            chk("instr_o", instr_o, w);
            chk("decode_fields", {funct7_o, funct3_o, opcode_o}, {w[31:25], w[14:12], w[6:0]});
            if (fresh_pc) begin first_pc = pc_o; fresh_pc = 1'b0; end
            if (first_val < 0) first_val = cyc;
            if (instr_ready_i) begin dut_xfers++; last_dut_pc = pc_o; end
        end
        if (rv) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) buffered++;
        end
        if (exp_valid && instr_ready_i) begin buffered--; exp_pc += 32'd4; end
        if (exp_req && g) begin pend.push_back(pend_t'{epoch, exp_fetch}); exp_fetch += 32'd4; end
        if (redir) begin
            epoch++;
            buffered   = 0;
            exp_pc     = tgt & ~32'd3;
            exp_fetch  = tgt & ~32'd3;
            fresh_pc   = 1'b1;
            fresh_addr = 1'b1;
            first_pc   = 'x;
            first_addr = 'x;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        running = rst_ni;
    endtask

    initial begin
        int target;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_req", imem_req_o, 1'b0);
        chk("reset_valid", instr_valid_o, 1'b0);
        chk("reset_addr", imem_addr_o, 32'h0);
        rst_ni = 1'b1;

        // Boot fetch with decode stalled: latency and two-entry fill.
        repeat (10) step();
        chk("first_grant_cycle", first_gnt, 1);
        chk("grant_to_valid", first_val - first_gnt, 2);
        chk("stall_grants", dut_grants, 2);
        chk("stall_req", imem_req_o, 1'b0);
        chk("stall_head_pc", pc_o, 32'h0);

        // Streaming with decode always ready.
        rdy_pct = 100;
        target = dut_xfers;
        repeat (30) step();
        chk("stream_progress", dut_xfers - target >= 15, 1'b1);

        // Redirect with two requests in flight.
        rv_pct = 0;
        for (int i = 0; i < 10 && pend.size() < 2; i++) step();
        chk("full_no_req", imem_req_o, 1'b0);
        step(1'b1, 32'h103);
        rv_pct = 100;
        for (int i = 0; i < 20 && fresh_pc; i++) step();
        chk("redirect_first_addr", first_addr, 32'h100);
        chk("redirect_first_pc", first_pc, 32'h100);

        // Second redirect while still draining.
        rv_pct = 0;
        for (int i = 0; i < 10 && pend.size() < 2; i++) step();
        step(1'b1, 32'h500);
        step();
        step(1'b1, 32'h200);
        rv_pct = 100;
        for (int i = 0; i < 20 && fresh_pc; i++) step();
        chk("drain_redirect_addr", first_addr, 32'h200);
        chk("drain_redirect_pc", first_pc, 32'h200);

        // Grant withheld at the top of the address space, then wrap.
        gnt_pct = 0;
        step(1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 10 && fresh_addr; i++) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_req", imem_req_o, 1'b1);
            chk("held_addr", imem_addr_o, 32'hFFFF_FFFC);
        end
        gnt_pct = 100;
        target = dut_xfers + 2;
        for (int i = 0; i < 20 && dut_xfers < target; i++) step();
        chk("wrap_pc", last_dut_pc, 32'h0);

        // Random traffic with occasional redirects.
        gnt_pct = 60; rv_pct = 50; rdy_pct = 70;
        target = dut_xfers;
        for (int i = 0; i < 600; i++) step($urandom_range(99) < 4, $urandom);
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        repeat (10) step();
        chk("random_progress", dut_xfers > target, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_req", imem_req_o, 1'b0);
        chk("async_reset_valid", instr_valid_o, 1'b0);
        chk("async_reset_addr", imem_addr_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
